// File: rtl/des_round_controller.sv
// -----------------------------------------------------------------------------
// des_round_controller
//
// Control sequencer for an iterative DES datapath that executes one round per
// clock. It takes one block/key job through an input handshake, drives the
// datapath load, the per-round enables, the round index and the key-schedule
// rotate controls, then the final-permutation capture, and presents the result
// through an output handshake. It carries no data.
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready are
// both high. A producer holds valid (and its data) until the transfer; valid
// never drops without a transfer except on reset. in_ready may depend
// combinationally on out_ready (back-to-back accept while handing off).
//
// Optional build macro: DES_ABORT_EN adds the abort input, which cancels an
// in-flight job (ROUND or FINAL) and returns to IDLE without a result.
//
// Parameters:
//   NUM_ROUNDS  rounds per block (16 for DES, 1..16 for test builds)
//   RIDX_W      width of round_idx, must hold NUM_ROUNDS
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   abort          (DES_ABORT_EN only) cancel the in-flight job
//   in_valid       requester has a block/key pair ready
//   in_ready       controller accepts a job this cycle
//   mode_decrypt   sampled on accept: 0 = encrypt, 1 = decrypt
//   dp_load        datapath captures IP(block) and PC1(key)
//   dp_round_en    datapath executes one round
//   round_idx      current round 1..NUM_ROUNDS, 0 outside rounds
//   shift_amt      key rotate amount for this round (0, 1 or 2)
//   shift_left     rotate direction: 1 = left (encrypt), 0 = right (decrypt)
//   dp_final       datapath swaps L/R, applies IP^-1, registers the output
//   out_valid      result register holds a valid block
//   out_ready      consumer takes the result
//   busy           high in any state other than IDLE
//   dbg_state      current FSM state (0 IDLE, 1 ROUND, 2 FINAL, 3 DONE)
// -----------------------------------------------------------------------------
module des_round_controller #(
  parameter int NUM_ROUNDS = 16,
  parameter int RIDX_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef DES_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode_decrypt,
  output logic              dp_load,
  output logic              dp_round_en,
  output logic [RIDX_W-1:0] round_idx,
  output logic [1:0]        shift_amt,
  output logic              shift_left,
  output logic              dp_final,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [RIDX_W-1:0] CNT_ONE  = RIDX_W'(1);
  localparam logic [RIDX_W-1:0] CNT_LAST = RIDX_W'(NUM_ROUNDS);

  state_t            state, state_nxt;
  logic [RIDX_W-1:0] cnt, cnt_nxt;
  logic              mode_q, mode_nxt;
  logic              accept;
  logic              abort_hit;
  logic [31:0]       rnd;

  // A new job can enter from IDLE, or from DONE in the same cycle the result
  // leaves, which removes the idle bubble between consecutive blocks.
  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

`ifdef DES_ABORT_EN
  // Only an in-flight job can be cancelled; a finished result is kept.
  assign abort_hit = abort & ((state == S_ROUND) | (state == S_FINAL));
`else
  assign abort_hit = 1'b0;
`endif

  // Round number widened so the fixed DES schedule positions (9, 16) never
  // alias onto low rounds in narrow test builds.
  assign rnd = 32'(cnt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    if (accept) begin
      mode_nxt = mode_decrypt;
    end
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_ROUND;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_ROUND: begin
        if (abort_hit) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_FINAL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_FINAL: begin
        state_nxt = abort_hit ? S_IDLE : S_DONE;
        cnt_nxt   = '0;
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_nxt = S_ROUND;
            cnt_nxt   = CNT_ONE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    dp_load     = accept;
    dp_round_en = 1'b0;
    round_idx   = '0;
    shift_amt   = 2'd0;
    shift_left  = 1'b0;
    dp_final    = 1'b0;
    out_valid   = 1'b0;
    busy        = (state != S_IDLE);
    dbg_state   = state;
    case (state)
      S_ROUND: begin
        dp_round_en = 1'b1;
        round_idx   = cnt;
        shift_left  = ~mode_q;
        // Decryption rotates right and skips the rotate in round 1, so the
        // key starts from the same C/D halves that encryption ended on.
        if (mode_q && (rnd == 32'd1)) begin
          shift_amt = 2'd0;
        end else if ((rnd == 32'd1) || (rnd == 32'd2) ||
                     (rnd == 32'd9) || (rnd == 32'd16)) begin
          shift_amt = 2'd1;
        end else begin
          shift_amt = 2'd2;
        end
      end
      S_FINAL: dp_final  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_des_round_controller.sv
// -----------------------------------------------------------------------------
// tb_des_round_controller
//
// Randomised and directed stimulus against a job-level reference model. The
// model predicts, from the inputs alone, when each job is accepted and pushes
// the complete expected event list of that job (every round with its index and
// rotate control, the final capture, the first cycle of out_valid) into
// exp_q, each tagged with its cycle. A separate monitor pops and compares
// whenever the DUT presents one of those outputs.
// -----------------------------------------------------------------------------
module tb_des_round_controller;

  localparam int NR = 16;
  localparam int RW = 5;
  localparam int W  = 32;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          mode_decrypt = 1'b0;
  logic          out_ready = 1'b0;
  logic          abort = 1'b0;
  logic          in_ready;
  logic          dp_load;
  logic          dp_round_en;
  logic [RW-1:0] round_idx;
  logic [1:0]    shift_amt;
  logic          shift_left;
  logic          dp_final;
  logic          out_valid;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  des_round_controller #(.NUM_ROUNDS(NR), .RIDX_W(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef DES_ABORT_EN
    .abort        (abort),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode_decrypt (mode_decrypt),
    .dp_load      (dp_load),
    .dp_round_en  (dp_round_en),
    .round_idx    (round_idx),
    .shift_amt    (shift_amt),
    .shift_left   (shift_left),
    .dp_final     (dp_final),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int vecs = 0;
  int errs = 0;
  logic [W-1:0] exp_q[$];

  // DES key-schedule rotate amounts by round, straight from the standard
  // tables: encryption left shifts, decryption right shifts (first is 0).
  int enc_tab[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_tab[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Event word: cycle, kind (1 round, 2 final, 3 result), round, amount, dir.
  function automatic logic [W-1:0] mk_ev(int c, int kind, int r, int amt, int left);
    return {16'(c), 2'(kind), 5'(r), 2'(amt), 1'(left), 6'd0};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  bit m_active = 0;
  int m_start = 0;
  bit m_done;
  bit m_rdy;
  bit m_acc;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
      m_active = 0;
    end else begin
      m_done = m_active && (cyc >= m_start + NR + 2);
      m_rdy  = !m_active || (m_done && out_ready);
      m_acc  = in_valid && m_rdy;
      check("in_ready", 32'(in_ready), 32'(m_rdy));
      check("dp_load", 32'(dp_load), 32'(m_acc));
      check("busy", 32'(busy), 32'(m_active));
`ifdef DES_ABORT_EN
      if (m_active && !m_done && (cyc > m_start) && abort) begin
        m_active = 0;
        exp_q.delete();
      end
`endif
      if (m_acc) begin
        m_active = 1;
        m_start  = cyc;
        for (int r = 1; r <= NR; r++) begin
          if (mode_decrypt)
            exp_q.push_back(mk_ev(cyc + r, 1, r, dec_tab[r-1], 0));
          else
            exp_q.push_back(mk_ev(cyc + r, 1, r, enc_tab[r-1], 1));
        end
        exp_q.push_back(mk_ev(cyc + NR + 1, 2, 0, 0, 0));
        exp_q.push_back(mk_ev(cyc + NR + 2, 3, 0, 0, 0));
      end else if (m_done && out_ready) begin
        m_active = 0;
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  bit ov_seen = 0;
  bit prev_ov = 0;
  bit prev_or = 0;
  logic [W-1:0] act_ev;

  task automatic take(string name, logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      vecs++;
      errs++;
      $display("FAIL unexpected_%s at cycle %0d: got %0h expected none", name, cyc, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_seen = 0;
      prev_ov = 0;
      prev_or = 0;
    end else begin
      while (exp_q.size() > 0 && int'(exp_q[0][31:16]) < cyc) begin
        vecs++;
        errs++;
        $display("FAIL missed_event at cycle %0d: got none expected %0h", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (dp_round_en) begin
        act_ev = mk_ev(cyc, 1, int'(round_idx), int'(shift_amt), int'(shift_left));
        take("round_event", act_ev);
      end else begin
        check("idle_round_ctl", {25'd0, round_idx, shift_amt, shift_left}, 32'd0);
      end
      if (dp_final) take("final_event", mk_ev(cyc, 2, 0, 0, 0));
      if (out_valid && !ov_seen) begin
        take("result_event", mk_ev(cyc, 3, 0, 0, 0));
        ov_seen = 1;
      end
      if (prev_ov && !prev_or) check("out_valid_hold", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) ov_seen = 0;
      prev_ov = out_valid;
      prev_or = out_ready;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs();
    check("reset_outputs",
          {22'd0, dp_load, dp_round_en, round_idx, shift_amt, shift_left, dp_final,
           out_valid, busy}, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Offer one job and hold it until it is taken (bounded).
  task automatic send(bit m);
    in_valid     = 1'b1;
    mode_decrypt = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        step(1);
        in_valid     = 1'b0;
        mode_decrypt = 1'($urandom_range(0, 1));
        return;
      end
    end
    vecs++;
    errs++;
    $display("FAIL accept_timeout at cycle %0d: got no accept expected accept", cyc);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    step(2);
    check_reset_outputs();
    rst_n = 1'b1;
    step(2);

    // Encrypt, then decrypt, with the consumer always ready.
    out_ready = 1'b1;
    send(1'b0);
    step(NR + 4);
    send(1'b1);
    step(NR + 4);

    // Backpressure with nothing pending: result held, then IDLE on release.
    out_ready = 1'b0;
    send(1'($urandom_range(0, 1)));
    step(NR + 12);
    out_ready = 1'b1;
    step(3);

    // Backpressure with a second job waiting: it must not load until the
    // result is taken, then loads in the handoff cycle.
    out_ready = 1'b0;
    send(1'($urandom_range(0, 1)));
    in_valid     = 1'b1;
    mode_decrypt = 1'($urandom_range(0, 1));
    step(NR + 12);
    out_ready = 1'b1;
    send(mode_decrypt);
    step(NR + 4);

    // Continuous back-to-back jobs; mode changes every cycle so only the
    // value present at accept may matter.
    in_valid = 1'b1;
    for (int i = 0; i < 3 * (NR + 2) + 2; i++) begin
      mode_decrypt = 1'($urandom_range(0, 1));
      step(1);
    end
    in_valid = 1'b0;
    step(NR + 4);

    // Reset while round 7 is on the datapath, then a normal job.
    send(1'b0);
    step(6);
    pulse_reset();
    out_ready = 1'b1;
    send(1'b1);
    step(NR + 4);

`ifdef DES_ABORT_EN
    // Abort during round 10: nothing further from that job.
    send(1'b0);
    step(9);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(NR + 4);
    // Abort while the result waits: the result survives.
    out_ready = 1'b0;
    send(1'b1);
    step(NR + 2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(3);
    out_ready = 1'b1;
    step(3);
`endif

    // Random traffic on both handshakes.
    for (int i = 0; i < 800; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      mode_decrypt = 1'($urandom_range(0, 1));
`ifdef DES_ABORT_EN
      abort = ($urandom_range(0, 40) == 0);
`endif
      step(1);
    end
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    step(NR + 6);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
